// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   INST_NOP      : instruction word loaded into IF/ID when no valid word exists
//   if_state_e    : fetch FSM states (BOOT, RUN, STALL, DRAIN)
//   fetch_word_t  : one fetched slot {pc, inst} (plus misalign flag when
//                   IF_ALIGN_CHECK_EN is defined), used by IF/ID and the skid
package if_fetch_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_STALL = 2'd2,
    IF_DRAIN = 2'd3
  } if_state_e;

  typedef struct packed {
`ifdef IF_ALIGN_CHECK_EN
    logic        misalign;
`endif
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction ROM bus between the fetch stage and a synchronous ROM.
//   inst_ce    : read enable, one read per asserted cycle
//   inst_addr  : byte address
//   inst_rdata : read data, valid the cycle after inst_ce=1
// master = fetch stage, slave = ROM.
interface if_fetch_if;

  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;

  modport master (output inst_ce, output inst_addr, input  inst_rdata);
  modport slave  (input  inst_ce, input  inst_addr, output inst_rdata);

endinterface

// File: rtl/if_fetch_skid_buf.sv
// if_skid_buf: 1-entry holding register for a fetched slot that arrives
// while the decode stage is stalled.
//   clk, rst  : clock, synchronous active-low reset
//   load_i    : capture data_i (takes priority over unload_i)
//   unload_i  : release the held entry
//   data_i    : incoming slot
//   valid_o   : entry held
//   data_o    : held slot
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        unload_i,
  input  fetch_word_t data_i,
  output logic        valid_o,
  output fetch_word_t data_o
);

  logic        valid_q, valid_d;
  fetch_word_t data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Owns the PC, issues reads to a
// synchronous ROM and drives the IF/ID register into decode. MIPS
// delay-slot semantics: the word in flight when a redirect is taken is
// always delivered, and the redirect costs no bubble.
//   clk, rst          : clock, synchronous active-low reset
//   rom               : ROM bus (inst_ce / inst_addr / inst_rdata)
//   stall_i           : decode holds its instruction this cycle
//   branch_flag_i     : redirect for the instruction on pc_o/inst_o
//   target_address_i  : redirect target
//   pc_o, inst_o      : IF/ID register (inst_o = 0 when no valid word)
//   valid_o           : IF/ID holds a fetched instruction
//   fetch_misalign_o  : only with IF_ALIGN_CHECK_EN; slot came from a
//                       misaligned address and was not sent to the ROM
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_if.master        rom,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       target_address_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              valid_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic              fetch_misalign_o
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  fetch_word_t ifid_q, ifid_d;
  logic        valid_q, valid_d;
`ifdef IF_ALIGN_CHECK_EN
  logic        req_mis_q, req_mis_d;
`endif

  logic        issue, misalign;
  logic [31:0] addr;
  fetch_word_t resp, skid_data;
  logic        skid_load, skid_unload, skid_valid;

  // Issue path and PC mux
  always_comb begin
    issue = rst && (state_q == IF_RUN) && !stall_i;
    addr  = redir_pend_q  ? redir_tgt_q :
            branch_flag_i ? target_address_i : fetch_pc_q;
`ifdef IF_ALIGN_CHECK_EN
    misalign = (addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
  end

  assign rom.inst_ce   = issue && !misalign;
  assign rom.inst_addr = addr;

  // Returned slot; a misaligned slot is delivered as a nop without a ROM read
  always_comb begin
    resp.pc   = req_pc_q;
    resp.inst = rom.inst_rdata;
`ifdef IF_ALIGN_CHECK_EN
    resp.misalign = req_mis_q;
    if (req_mis_q) resp.inst = INST_NOP;
`endif
  end

  // Issue stops the cycle stall_i rises, so at most one word ever needs parking.
  assign skid_load   = req_valid_q && stall_i;
  assign skid_unload = (state_q == IF_DRAIN) && !stall_i && skid_valid;

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (resp),
    .valid_o  (skid_valid),
    .data_o   (skid_data)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_valid_d  = issue;
    req_pc_d     = req_pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    ifid_d       = ifid_q;
    valid_d      = valid_q;
`ifdef IF_ALIGN_CHECK_EN
    req_mis_d    = req_mis_q;
`endif

    case (state_q)
      IF_BOOT:  state_d = IF_RUN;
      IF_RUN:   if (stall_i) state_d = IF_STALL;
      IF_STALL: if (!stall_i) state_d = skid_valid ? IF_DRAIN : IF_RUN;
      IF_DRAIN: state_d = stall_i ? IF_STALL : IF_RUN;
      default:  state_d = IF_BOOT;
    endcase

    if (issue) begin
      fetch_pc_d   = addr + PC_STEP;
      req_pc_d     = addr;
      redir_pend_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      req_mis_d    = misalign;
`endif
    end else if (branch_flag_i && !stall_i) begin
      // No slot to steer this cycle: remember the target for the next issue.
      redir_pend_d = 1'b1;
      redir_tgt_d  = target_address_i;
    end

    // While the skid is held outside DRAIN (stall release cycle) IF/ID keeps
    // its word so the skid word follows it in order.
    if (!stall_i) begin
      if (req_valid_q) begin
        ifid_d  = resp;
        valid_d = 1'b1;
      end else if (skid_unload) begin
        ifid_d  = skid_data;
        valid_d = 1'b1;
      end else if (!skid_valid) begin
        ifid_d.inst = INST_NOP;
`ifdef IF_ALIGN_CHECK_EN
        ifid_d.misalign = 1'b0;
`endif
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IF_BOOT;
      fetch_pc_q   <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      ifid_q       <= '0;
      valid_q      <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      req_mis_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      ifid_q       <= ifid_d;
      valid_q      <= valid_d;
`ifdef IF_ALIGN_CHECK_EN
      req_mis_q    <= req_mis_d;
`endif
    end
  end

  assign pc_o    = ifid_q.pc;
  assign inst_o  = ifid_q.inst;
  assign valid_o = valid_q;
`ifdef IF_ALIGN_CHECK_EN
  assign fetch_misalign_o = ifid_q.misalign;
`endif

endmodule
